// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game FSM, tick generation, collision edge-detect and
// tick-aligned arbitration, score count, digit multiplex and end-of-game blink.
module snake_game_ctrl #(
    parameter int TICK_DIV  = 10,
    parameter int MAX_SCORE = 50,
    parameter int BLINK_DIV = 25
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       start_i,
    input  logic       good_i,
    input  logic       bad_i,
    output logic       tick,
    output logic       goodColl,
    output logic       badColl,
    output logic [1:0] state,
    output logic [6:0] score_cnt,
    output logic       digit_sel,
    output logic       blank
);

    localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [6:0]    SCORE_MAX  = 7'(MAX_SCORE);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, OVER = 2'b10, WIN = 2'b11} state_t;

    state_t          state_q, state_d;
    logic [2:0]      sync_q1, sync_q2;
    logic [TW-1:0]   tick_cnt;
    logic [BW-1:0]   blink_cnt;
    logic            pend_good, pend_bad;
    logic            tick_q, good_q, bad_q, digit_q, blank_q;
    logic [6:0]      score_q;

    logic            start_edge, good_edge, bad_edge;
    logic            decide, eff_good, eff_bad, fire_good, fire_bad;
    logic            restart, blink_hold;
    logic [6:0]      score_inc;

    // Two-stage capture of the raw requests; bit order {start, good, bad}.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {start_i, good_i, bad_i};
            sync_q2 <= sync_q1;
        end
    end

    assign start_edge = sync_q1[2] & ~sync_q2[2];
    assign good_edge  = sync_q1[1] & ~sync_q2[1];
    assign bad_edge   = sync_q1[0] & ~sync_q2[0];

    // FSM: state register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_edge) state_d = RUN;
            RUN: begin
                if (fire_bad)                                state_d = OVER;
                else if (fire_good && score_inc == SCORE_MAX) state_d = WIN;
            end
            default:  if (start_edge) state_d = RUN;
        endcase
    end

    // FSM: decision outputs; an edge arriving on the tick cycle is serviced on that tick.
    always_comb begin
        decide     = (state_q == RUN) && (tick_cnt == TICK_LAST);
        eff_good   = pend_good | good_edge;
        eff_bad    = pend_bad  | bad_edge;
        fire_bad   = decide & eff_bad;
        fire_good  = decide & ~eff_bad & eff_good;
        score_inc  = score_q + 7'd1;
        restart    = start_edge && (state_q != RUN);
        // Blink only while staying in OVER/WIN, so entry and exit both see a clean phase.
        blink_hold = ((state_q == OVER) || (state_q == WIN)) && (state_d == state_q);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tick_cnt  <= '0;
            pend_good <= 1'b0;
            pend_bad  <= 1'b0;
            tick_q    <= 1'b0;
            good_q    <= 1'b0;
            bad_q     <= 1'b0;
            score_q   <= '0;
        end else begin
            tick_q <= decide;
            good_q <= fire_good;
            bad_q  <= fire_bad;

            if (state_q != RUN)  tick_cnt <= '0;
            else if (decide)     tick_cnt <= '0;
            else                 tick_cnt <= tick_cnt + 1'b1;

            if (state_q != RUN) begin
                pend_good <= 1'b0;
                pend_bad  <= 1'b0;
            end else if (decide) begin
                if (eff_bad) begin
                    pend_good <= 1'b0;
                    pend_bad  <= 1'b0;
                end else if (eff_good) begin
                    pend_good <= 1'b0;
                end
            end else begin
                pend_good <= pend_good | good_edge;
                pend_bad  <= pend_bad  | bad_edge;
            end

            if (restart)        score_q <= '0;
            else if (fire_good) score_q <= score_inc;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            digit_q   <= 1'b0;
            blink_cnt <= '0;
            blank_q   <= 1'b0;
        end else begin
            digit_q <= ~digit_q;
            if (!blink_hold) begin
                blink_cnt <= '0;
                blank_q   <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blank_q   <= ~blank_q;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign tick      = tick_q;
    assign goodColl  = good_q;
    assign badColl   = bad_q;
    assign state     = state_q;
    assign score_cnt = score_q;
    assign digit_sel = digit_q;
    assign blank     = blank_q;

endmodule
